// File: rtl/icache_dm_refill.sv
// icache_dm_refill
//   Direct-mapped instruction cache placed between the fetch stage and a
//   word-wide backing memory. Hits return the 32-bit big-endian word in the
//   same cycle with no stall. A miss raises stall and refills the whole line
//   word by word, in ascending order starting at word 0. flush clears every
//   valid bit at the next edge. In METAL mode the fetch address is masked to
//   a 64 KiB window before lookup and refill.
//
//   Memory handshake: a word transfers on a rising edge where mem_req and
//   mem_valid are both high. mem_req/mem_addr hold steady until that edge.
//   mem_valid while mem_req is low is ignored. Only one word is outstanding.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   addr        fetch byte address (bits [1:0] ignored)
//   read_en     fetch request this cycle
//   data        instruction word, valid when read_en & !stall
//   stall       fetch must hold addr/read_en and retry
//   flush       invalidate all lines
//   mem_req     backing-memory word request
//   mem_addr    word-aligned byte address of the requested word
//   mem_data    returned word, already big-endian assembled
//   mem_valid   mem_data valid; accepts the current request
//   o_dbg_state FSM state (0 = IDLE, 1 = REFILL)

module icache_dm_refill #(
  parameter int METAL      = 0,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr,
  input  logic        read_en,
  output logic [31:0] data,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_valid,
  output logic        o_dbg_state
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int LSB_IDX = 2 + OFF_W;
  localparam int LSB_TAG = LSB_IDX + IDX_W;
  localparam int TAG_W   = 64 - LSB_TAG;
  localparam int LINE_W  = 64 - LSB_IDX;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];

  // Line number (address above the offset bits) of the line being filled.
  logic [LINE_W-1:0] r_line;
  logic [OFF_W-1:0]  r_beat;

  logic [63:0]      w_a;
  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_hit;
  logic             w_accept;
  logic             w_last;
  logic             w_start;
  logic             w_done;
  logic             w_unused;

  assign w_a   = (METAL != 0) ? (addr & 64'h0000_0000_0000_ffff) : addr;
  assign w_off = w_a[LSB_IDX-1:2];
  assign w_idx = w_a[LSB_TAG-1:LSB_IDX];
  assign w_tag = w_a[63:LSB_TAG];

  assign w_fill_idx = r_line[IDX_W-1:0];
  assign w_fill_tag = r_line[LINE_W-1:IDX_W];

  // Byte-select bits never take part in lookup.
  assign w_unused = ^w_a[1:0];

  // A flush in the same cycle as a would-be hit still stalls.
  assign w_hit = read_en & r_valid[w_idx] & (r_tag[w_idx] == w_tag) &
                 (r_state == S_IDLE) & ~flush;

  assign stall = ~reset & read_en & ~w_hit;
  assign data  = r_data[w_idx][w_off];

  assign mem_req     = (r_state == S_REFILL);
  assign mem_addr    = mem_req ? {r_line, r_beat, 2'b00} : 64'd0;
  assign o_dbg_state = (r_state == S_REFILL);

  // A beat returned in the same cycle as flush is discarded.
  assign w_accept = mem_req & mem_valid & ~flush;
  assign w_last   = (r_beat == OFF_W'(LINE_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (read_en & ~w_hit & ~flush) begin
          w_state_nxt = S_REFILL;
          w_start     = 1'b1;
        end
      end
      S_REFILL: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept & w_last) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_beat  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_valid <= '0;
      end else if (w_done) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (w_start) begin
        r_line <= w_a[63:LSB_IDX];
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data[w_fill_idx][r_beat] <= mem_data;
      if (w_last) begin
        r_tag[w_fill_idx] <= w_fill_tag;
      end
    end
  end

endmodule
